seq_alu: RTL
============

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (legal range 4..64).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: the operation request is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept a request; asserted exactly when the state is IDLE.
REQ-006 SHALL have ports A and B, input, WIDTH bits each: the operands.
REQ-007 SHALL have port opcode, input, 4 bits: operation select.
REQ-008 SHALL have port out_valid, output, 1 bit: the result and flags are valid.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 SHALL have port result, output, WIDTH bits: the registered result.
REQ-011 SHALL have ports carry, zero, negative and overflow, output, 1 bit each: the registered flags.

Function
REQ-012 SHALL use an FSM with states IDLE, BUSY and DONE.
REQ-013 SHALL accept a request on a rising edge where in_valid=1 and in_ready=1, capturing A, B and opcode; in_valid in any other state SHALL be ignored.
REQ-014 Single-cycle opcodes 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR and 5 SLT (signed less-than, result 1 or 0) SHALL:
- register result and flags on the accepting edge;
- go IDLE->DONE, so out_valid is high in the cycle after acceptance.
REQ-015 Opcode 6 MUL (unsigned shift-add, low WIDTH bits of the product) and opcode 7 DIVU (unsigned restoring division, quotient) SHALL:
- go IDLE->BUSY and iterate exactly WIDTH cycles;
- then go BUSY->DONE, with out_valid first high WIDTH+1 cycles after the accepting edge.
REQ-016 Opcodes 8-15 SHALL be illegal:
- result=0, zero=1, other flags 0;
- same latency as single-cycle opcodes.
REQ-017 ADD flags: carry=unsigned carry-out; overflow=signed two's-complement overflow.
REQ-018 SUB flags: carry=1 when A>=B unsigned (no borrow); overflow=signed overflow.
REQ-019 Opcodes 2-5: carry=0 and overflow=0.
REQ-020 MUL: carry=overflow=1 when the upper WIDTH bits of the full product are non-zero.
REQ-021 DIVU:
- carry=0;
- B=0 SHALL give result all-ones and overflow=1, still taking WIDTH cycles.
REQ-022 For every opcode: zero=(result==0) and negative=result[WIDTH-1].
REQ-023 In DONE, result and flags SHALL hold stable while out_ready=0.
REQ-024 DONE SHALL go to IDLE on the edge where out_valid=1 and out_ready=1, so in_ready is high in the next cycle; maximum throughput is one single-cycle op per 2 cycles.
REQ-025 Operand changes after acceptance SHALL NOT affect an operation in progress.

Reset
REQ-026 While rst_n=0, the block SHALL be forced to:
- state IDLE and iteration counter 0;
- out_valid=0, result=0 and all flags 0;
- in_ready=1.
REQ-027 Reset asserted mid-operation (BUSY or DONE) SHALL abort immediately with no residual output; the first request after release SHALL be computed correctly.

Verification (WIDTH=8)
REQ-028 ADD 200+100 -> result 44, carry=1, overflow=0, negative=0, zero=0, out_valid one cycle after accept.
REQ-029 SUB 5-7 -> result 254, carry=0, negative=1, overflow=0; SUB 128-1 -> result 127, overflow=1, carry=1.
REQ-030 MUL 15*17 -> 255, carry=0; MUL 16*16 -> 0, zero=1, carry=1, overflow=1; out_valid exactly 9 cycles after accept, in_ready=0 throughout.
REQ-031 DIVU 200/7 -> 28, overflow=0; DIVU 5/0 -> 255, overflow=1, negative=1, after 9 cycles.
REQ-032 Backpressure: out_ready=0 for 5 cycles after out_valid, with in_valid=1 and changing A/B/opcode -> result and flags unchanged, in_ready=0, no new request accepted; out_ready=1 -> in_ready=1 on the next cycle.
REQ-033 Mid-op reset: pulse rst_n low 4 cycles into a DIVU -> out_valid=0 and in_ready=1 immediately; next ADD 1+1 -> result 2.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with a valid/ready handshake on both sides.
// Single-cycle ops (ADD/SUB/AND/OR/XOR/SLT and illegal codes) finish on the
// accepting edge. MUL (shift-add) and DIVU (restoring) iterate WIDTH cycles in BUSY.
`timescale 1ns/1ps
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_next;

  logic [CW-1:0]      cnt;
  logic               is_div;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   rem_reg;
  logic [WIDTH-1:0]   quo_reg;
  logic [WIDTH-1:0]   div_reg;

  logic accept;
  logic multi_op;
  logic finish;

  assign accept   = in_valid && (state == IDLE);
  assign multi_op = (opcode == 4'd6) || (opcode == 4'd7);
  // Last iteration: its outcome is registered straight into result, so
  // BUSY lasts exactly WIDTH cycles.
  assign finish   = (state == BUSY) && (cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = multi_op ? BUSY : DONE;
      end
      BUSY: begin
        if (finish) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Single-cycle operations, evaluated directly on the live operands
  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c;
  logic             sc_v;

  always_comb begin
    add_ext = {1'b0, A} + {1'b0, B};
    sub_ext = {1'b0, A} - {1'b0, B};
    sc_res  = '0;
    sc_c    = 1'b0;
    sc_v    = 1'b0;
    case (opcode)
      4'd0: begin
        sc_res = add_ext[WIDTH-1:0];
        sc_c   = add_ext[WIDTH];
        sc_v   = (A[WIDTH-1] == B[WIDTH-1]) && (add_ext[WIDTH-1] != A[WIDTH-1]);
      end
      4'd1: begin
        sc_res = sub_ext[WIDTH-1:0];
        sc_c   = ~sub_ext[WIDTH];            // no borrow means A >= B
        sc_v   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_ext[WIDTH-1] != A[WIDTH-1]);
      end
      4'd2: sc_res = A & B;
      4'd3: sc_res = A | B;
      4'd4: sc_res = A ^ B;
      4'd5: sc_res[0] = ($signed(A) < $signed(B));
      default: sc_res = '0;                  // illegal codes and the multi-cycle codes
    endcase
  end

  // One step of the shift-add multiplier and of the restoring divider
  logic [2*WIDTH-1:0] mul_acc_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic               div_fit;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH-1:0]   busy_res;
  logic               busy_hi;

  always_comb begin
    mul_acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
    div_shift    = {rem_reg, quo_reg[WIDTH-1]};
    div_trial    = div_shift - {1'b0, div_reg};
    div_fit      = ~div_trial[WIDTH];
    rem_next     = div_fit ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    // With a zero divisor every trial fits, so the quotient comes out all-ones.
    quo_next     = {quo_reg[WIDTH-2:0], div_fit};
    busy_hi      = |mul_acc_next[2*WIDTH-1:WIDTH];
    busy_res     = is_div ? quo_next : mul_acc_next[WIDTH-1:0];
  end

  // Value written into the output registers when an operation completes
  logic             load_en;
  logic [WIDTH-1:0] load_res;
  logic             load_c;
  logic             load_v;

  always_comb begin
    load_en  = (accept && !multi_op) || finish;
    load_res = sc_res;
    load_c   = sc_c;
    load_v   = sc_v;
    if (state == BUSY) begin
      load_res = busy_res;
      load_c   = is_div ? 1'b0 : busy_hi;
      load_v   = is_div ? (div_reg == '0) : busy_hi;
    end
  end

  // Operand capture, iteration and result/flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      is_div     <= 1'b0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      rem_reg    <= '0;
      quo_reg    <= '0;
      div_reg    <= '0;
      result     <= '0;
      carry      <= 1'b0;
      zero       <= 1'b0;
      negative   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (accept && multi_op) begin
        is_div     <= opcode[0];
        mcand_reg  <= {{WIDTH{1'b0}}, A};
        mplier_reg <= B;
        acc_reg    <= '0;
        rem_reg    <= '0;
        quo_reg    <= A;
        div_reg    <= B;
        cnt        <= '0;
      end
      if (state == BUSY) begin
        cnt        <= finish ? '0 : cnt + CW'(1);
        acc_reg    <= mul_acc_next;
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_reg >> 1;
        rem_reg    <= rem_next;
        quo_reg    <= quo_next;
      end
      if (load_en) begin
        result   <= load_res;
        carry    <= load_c;
        overflow <= load_v;
        zero     <= (load_res == '0);
        negative <= load_res[WIDTH-1];
      end
    end
  end

endmodule
